// File: rtl/regfile_wr_arbiter_if.sv
// Write-back request bus between producers and the register-file write arbiter.
// Requester i owns addr bits [i*AW +: AW] and data bits [i*DW +: DW].
interface regfile_wr_arbiter_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    // Producer side
    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    // Arbiter side
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter and sequencer for the register-file write port (we3/ra3/wd3).
// Grants one producer per cycle, registers the write, and flags read-after-write
// hazards on the two read ports.
// Optional macro REGWR_ARB_R15_GUARD_EN: writes to R15 are consumed but dropped,
// and err_r15 pulses for one cycle instead.
module regfile_wr_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wr_arbiter_if.slave  req,
    input  logic                 wb_stall,
    input  logic [AW-1:0]        ra1,
    input  logic [AW-1:0]        ra2,
    output logic                 we3,
    output logic [AW-1:0]        ra3,
    output logic [DW-1:0]        wd3,
    output logic                 hazard1,
    output logic                 hazard2,
    output logic                 err_r15
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] R15 = AW'(15);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_n;
    logic            we3_n;
    logic [AW-1:0]   ra3_n;
    logic [DW-1:0]   wd3_n;
    logic            err_n;

    logic [NREQ-1:0] ready_c;
    logic            found_c;
    logic [PW-1:0]   win_c;
    int unsigned     idx;
    logic            grant_c;
    logic [AW-1:0]   sel_addr_c;
    logic [DW-1:0]   sel_data_c;

    // Scan requesters starting at ptr; first valid one wins unless stalled or in reset
    always_comb begin
        ready_c = '0;
        found_c = 1'b0;
        win_c   = ptr;
        idx     = 0;
        for (int unsigned o = 0; o < NREQ; o++) begin
            idx = 32'(ptr) + o;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found_c && req.req_valid[idx]) begin
                found_c = 1'b1;
                win_c   = PW'(idx);
            end
        end
        if (rst_n && !wb_stall && found_c) ready_c[win_c] = 1'b1;
    end

    assign req.req_ready = ready_c;
    assign grant_c       = |ready_c;
    assign sel_addr_c    = req.req_addr[32'(win_c)*AW +: AW];
    assign sel_data_c    = req.req_data[32'(win_c)*DW +: DW];

    // Next-state for pointer and write-port registers
    always_comb begin
        ptr_n = ptr;
        we3_n = 1'b0;
        ra3_n = ra3;
        wd3_n = wd3;
        err_n = 1'b0;
        if (grant_c) begin
            ptr_n = (win_c == PW'(NREQ - 1)) ? '0 : PW'(win_c + 1'b1);
`ifdef REGWR_ARB_R15_GUARD_EN
            if (sel_addr_c == R15) begin
                err_n = 1'b1;
            end else begin
                we3_n = 1'b1;
                ra3_n = sel_addr_c;
                wd3_n = sel_data_c;
            end
`else
            we3_n = 1'b1;
            ra3_n = sel_addr_c;
            wd3_n = sel_data_c;
`endif
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
            we3 <= 1'b0;
            ra3 <= '0;
            wd3 <= '0;
        end else begin
            ptr <= ptr_n;
            we3 <= we3_n;
            ra3 <= ra3_n;
            wd3 <= wd3_n;
        end
    end

`ifdef REGWR_ARB_R15_GUARD_EN
    // One-cycle pulse for a dropped R15 write
    always_ff @(posedge clk) begin
        if (!rst_n) err_r15 <= 1'b0;
        else        err_r15 <= err_n;
    end
`else
    assign err_r15 = 1'b0;
    logic unused_err;
    assign unused_err = err_n;
`endif

    // R15 reads come from PC+8, so never a hazard against the file
    assign hazard1 = we3 && (ra1 == ra3) && (ra1 != R15);
    assign hazard2 = we3 && (ra2 == ra3) && (ra2 != R15);

endmodule
